// File: rtl/mem_wb_pkg.sv
// ---------------------------------------------------------------------------
// mem_wb_pkg
// Shared types for the elastic MEM/WB stage.
//   MEM_WB_XLEN / MEM_WB_RA_W : default datapath / register-address widths
//   mem_wb_payload_t          : packed payload at the default widths
//   mem_wb_occ_e              : occupancy of the 2-entry skid buffer
// ---------------------------------------------------------------------------
package mem_wb_pkg;

    localparam int unsigned MEM_WB_XLEN = 64;
    localparam int unsigned MEM_WB_RA_W = 5;

    typedef struct packed {
        logic [MEM_WB_XLEN-1:0] read_data;
        logic [MEM_WB_XLEN-1:0] result;
        logic [MEM_WB_RA_W-1:0] rd;
        logic                   memtoreg;
        logic                   regwrite;
    } mem_wb_payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } mem_wb_occ_e;

endpackage : mem_wb_pkg

// File: rtl/pipe_skid_slot.sv
// ---------------------------------------------------------------------------
// pipe_skid_slot
// Generic payload register with load enable and synchronous active-low clear.
//   clk_i  : rising-edge clock
//   clr_ni : synchronous clear to zero, active low (wins over load)
//   en_i   : load d_i on the next rising edge
//   d_i    : payload in
//   q_o    : registered payload
// ---------------------------------------------------------------------------
module pipe_skid_slot #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         clr_ni,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (!clr_ni) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule : pipe_skid_slot

// File: rtl/mem_wb_elastic.sv
// ---------------------------------------------------------------------------
// mem_wb_elastic
// Elastic MEM/WB pipeline stage: valid/ready handshake with a 2-entry skid
// buffer (head + skid slot), synchronous flush, and regwrite masking for
// destination register 0.
//
// Optional macro MEM_WB_WBMUX_EN adds out_wb_data, the writeback mux
// (memtoreg ? read_data : result) driven from the head slot.
//
// Ports
//   clk, reset (sync, active low), flush (sync clear of buffered entries)
//   in_valid / in_ready   : upstream handshake
//   in_read_data, in_result, in_rd, in_memtoreg, in_regwrite : payload in
//   out_valid / out_ready : downstream handshake
//   out_read_data, out_result, out_rd, out_memtoreg, out_regwrite : head
//   out_wb_data           : (MEM_WB_WBMUX_EN only) writeback data
// ---------------------------------------------------------------------------
module mem_wb_elastic
    import mem_wb_pkg::*;
#(
    parameter int unsigned XLEN = 64,
    parameter int unsigned RA_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_read_data,
    input  logic [XLEN-1:0] in_result,
    input  logic [RA_W-1:0] in_rd,
    input  logic            in_memtoreg,
    input  logic            in_regwrite,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_read_data,
    output logic [XLEN-1:0] out_result,
    output logic [RA_W-1:0] out_rd,
    output logic            out_memtoreg,
`ifdef MEM_WB_WBMUX_EN
    output logic            out_regwrite,
    output logic [XLEN-1:0] out_wb_data
`else
    output logic            out_regwrite
`endif
);

    // Same field layout as mem_wb_payload_t, but sized by this instance's
    // parameters so non-default widths work.
    typedef struct packed {
        logic [XLEN-1:0] read_data;
        logic [XLEN-1:0] result;
        logic [RA_W-1:0] rd;
        logic            memtoreg;
        logic            regwrite;
    } payload_t;

    localparam int unsigned PW = $bits(payload_t);

    mem_wb_occ_e state_q, state_d;
    payload_t    in_pl, head_d, head_q, skid_q;
    logic        push, pop;
    logic        head_load, skid_load, head_from_skid;

    // Writes to x0 are architecturally discarded; mask them at entry.
    always_comb begin
        in_pl           = '0;
        in_pl.read_data = in_read_data;
        in_pl.result    = in_result;
        in_pl.rd        = in_rd;
        in_pl.memtoreg  = in_memtoreg;
        in_pl.regwrite  = in_regwrite & (in_rd != '0);
    end

    // Handshake: in_ready depends only on the state register and reset.
    assign in_ready  = (state_q != FULL) & reset;
    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (push) state_d = HALF;
                HALF: begin
                    if (push && !pop)      state_d = FULL;
                    else if (!push && pop) state_d = EMPTY;
                end
                FULL:    if (pop) state_d = HALF;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Output / datapath-control logic. Flush blocks every load so the
    // dropped push never reaches a slot and old payload stays in place.
    always_comb begin
        head_load      = 1'b0;
        skid_load      = 1'b0;
        head_from_skid = 1'b0;
        if (!flush) begin
            case (state_q)
                EMPTY: head_load = push;
                HALF: begin
                    if (push && pop) head_load = 1'b1;
                    else if (push)   skid_load = 1'b1;
                end
                FULL: begin
                    if (pop) begin
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_d = head_from_skid ? skid_q : in_pl;

    pipe_skid_slot #(.W(PW)) u_head (
        .clk_i  (clk),
        .clr_ni (reset),
        .en_i   (head_load),
        .d_i    (head_d),
        .q_o    (head_q)
    );

    pipe_skid_slot #(.W(PW)) u_skid (
        .clk_i  (clk),
        .clr_ni (reset),
        .en_i   (skid_load),
        .d_i    (in_pl),
        .q_o    (skid_q)
    );

    assign out_read_data = head_q.read_data;
    assign out_result    = head_q.result;
    assign out_rd        = head_q.rd;
    assign out_memtoreg  = head_q.memtoreg;
    assign out_regwrite  = head_q.regwrite;

`ifdef MEM_WB_WBMUX_EN
    assign out_wb_data = head_q.memtoreg ? head_q.read_data : head_q.result;
`endif

endmodule : mem_wb_elastic

// File: tb/tb_mem_wb_elastic.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_elastic
// Directed self-checking bench for mem_wb_elastic (default parameters).
// Inputs change 1 ns after a rising edge; outputs are checked there too.
// ---------------------------------------------------------------------------
module tb_mem_wb_elastic;

    localparam int unsigned XLEN = 64;
    localparam int unsigned RA_W = 5;

    logic            clk = 1'b0;
    logic            reset, flush, in_valid, in_ready;
    logic [XLEN-1:0] in_read_data, in_result;
    logic [RA_W-1:0] in_rd;
    logic            in_memtoreg, in_regwrite;
    logic            out_valid, out_ready;
    logic [XLEN-1:0] out_read_data, out_result;
    logic [RA_W-1:0] out_rd;
    logic            out_memtoreg, out_regwrite;
`ifdef MEM_WB_WBMUX_EN
    logic [XLEN-1:0] out_wb_data;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    mem_wb_elastic #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_read_data  (in_read_data),
        .in_result     (in_result),
        .in_rd         (in_rd),
        .in_memtoreg   (in_memtoreg),
        .in_regwrite   (in_regwrite),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_read_data (out_read_data),
        .out_result    (out_result),
        .out_rd        (out_rd),
        .out_memtoreg  (out_memtoreg),
`ifdef MEM_WB_WBMUX_EN
        .out_regwrite  (out_regwrite),
        .out_wb_data   (out_wb_data)
`else
        .out_regwrite  (out_regwrite)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] res, input logic [RA_W-1:0] rd,
                         input logic [63:0] rdata, input logic m2r, input logic rw);
        in_valid     = v;
        in_result    = res;
        in_rd        = rd;
        in_read_data = rdata;
        in_memtoreg  = m2r;
        in_regwrite  = rw;
    endtask

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 64'h99, 5'd3, 64'h1234, 1'b1, 1'b1);

        // 1. reset held for 2 cycles with in_valid high
        tick();
        tick();
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_result", out_result, 64'd0);
        check("rst_read_data", out_read_data, 64'd0);
        check("rst_rd", {59'd0, out_rd}, 64'd0);
        check("rst_memtoreg", {63'd0, out_memtoreg}, 64'd0);
        check("rst_regwrite", {63'd0, out_regwrite}, 64'd0);
        reset = 1'b1;
        drive(1'b0, 64'h0, 5'd0, 64'h0, 1'b0, 1'b0);
        tick();
        check("rel_in_ready", {63'd0, in_ready}, 64'd1);
        check("rel_out_valid", {63'd0, out_valid}, 64'd0);

        // 2. stream of 4 at full throughput
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'((i + 1) * 16), 5'(i + 1), 64'(i), 1'b0, 1'b1);
            tick();
            check("strm_valid", {63'd0, out_valid}, 64'd1);
            check("strm_result", out_result, 64'((i + 1) * 16));
            check("strm_rd", {59'd0, out_rd}, 64'(i + 1));
            check("strm_in_ready", {63'd0, in_ready}, 64'd1);
        end
        drive(1'b0, 64'h0, 5'd0, 64'h0, 1'b0, 1'b0);
        tick();
        check("strm_drain", {63'd0, out_valid}, 64'd0);

        // 3. stall: fill both slots, then drain in order
        out_ready = 1'b0;
        drive(1'b1, 64'hAA, 5'd5, 64'h0, 1'b0, 1'b1);
        tick();
        check("stall_a_result", out_result, 64'hAA);
        check("stall_a_in_ready", {63'd0, in_ready}, 64'd1);
        drive(1'b1, 64'hBB, 5'd6, 64'h0, 1'b0, 1'b1);
        tick();
        check("full_in_ready", {63'd0, in_ready}, 64'd0);
        check("full_result", out_result, 64'hAA);
        drive(1'b0, 64'h0, 5'd0, 64'h0, 1'b0, 1'b0);
        tick();
        check("hold_result", out_result, 64'hAA);
        check("hold_rd", {59'd0, out_rd}, 64'd5);
        out_ready = 1'b1;
        check("drain_a", out_result, 64'hAA);
        tick();
        check("drain_b", out_result, 64'hBB);
        check("drain_b_rd", {59'd0, out_rd}, 64'd6);
        check("drain_b_ready", {63'd0, in_ready}, 64'd1);
        tick();
        check("drain_empty", {63'd0, out_valid}, 64'd0);

        // 4. rd == 0 masks regwrite only
        drive(1'b1, 64'h55, 5'd0, 64'h0, 1'b0, 1'b1);
        tick();
        check("x0_regwrite", {63'd0, out_regwrite}, 64'd0);
        check("x0_result", out_result, 64'h55);
        check("x0_valid", {63'd0, out_valid}, 64'd1);
        drive(1'b0, 64'h0, 5'd0, 64'h0, 1'b0, 1'b0);
        tick();

        // 5. flush while FULL with a concurrent push
        out_ready = 1'b0;
        drive(1'b1, 64'hC1, 5'd7, 64'h0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 64'hD1, 5'd8, 64'h0, 1'b0, 1'b1);
        tick();
        check("pre_flush_full", {63'd0, in_ready}, 64'd0);
        flush = 1'b1;
        drive(1'b1, 64'hEE, 5'd10, 64'h0, 1'b0, 1'b1);
        tick();
        flush = 1'b0;
        drive(1'b0, 64'h0, 5'd0, 64'h0, 1'b0, 1'b0);
        check("flush_valid", {63'd0, out_valid}, 64'd0);
        check("flush_in_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        tick();
        check("flush_no_ghost", {63'd0, out_valid}, 64'd0);
        drive(1'b1, 64'h77, 5'd9, 64'h0, 1'b0, 1'b1);
        tick();
        check("post_flush_result", out_result, 64'h77);
        check("post_flush_rd", {59'd0, out_rd}, 64'd9);

        // flush together with pop from HALF: consumed, stage empties
        flush = 1'b1;
        drive(1'b0, 64'h0, 5'd0, 64'h0, 1'b0, 1'b0);
        tick();
        flush = 1'b0;
        check("flush_pop_valid", {63'd0, out_valid}, 64'd0);

        // reset mid-operation discards both entries
        out_ready = 1'b0;
        drive(1'b1, 64'h11, 5'd1, 64'h0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 64'h22, 5'd2, 64'h0, 1'b0, 1'b1);
        tick();
        reset = 1'b0;
        tick();
        check("midrst_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_result", out_result, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
        reset = 1'b1;
        drive(1'b0, 64'h0, 5'd0, 64'h0, 1'b0, 1'b0);
        tick();
        check("midrst_stay_empty", {63'd0, out_valid}, 64'd0);

`ifdef MEM_WB_WBMUX_EN
        // 6. writeback mux
        out_ready = 1'b1;
        drive(1'b1, 64'hBEEF, 5'd4, 64'hDEAD, 1'b1, 1'b1);
        tick();
        check("wb_load", out_wb_data, 64'hDEAD);
        drive(1'b1, 64'hBEEF, 5'd4, 64'hDEAD, 1'b0, 1'b1);
        tick();
        check("wb_alu", out_wb_data, 64'hBEEF);
        drive(1'b0, 64'h0, 5'd0, 64'h0, 1'b0, 1'b0);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mem_wb_elastic
